// File: rtl/pwm_pkg.sv
// pwm_pkg: shared register map, field indices and reset values
// for the multi-channel PWM block.
package pwm_pkg;

  typedef enum logic [2:0] {
    REG_TMR_H,
    REG_TMR_L,
    REG_THRES_H,
    REG_THRES_L,
    REG_CYCLE_H,
    REG_CYCLE_L,
    REG_CTRL,
    REG_STATUS
  } reg_e;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_POL = 1;
  localparam int CTRL_CTR = 2;
  localparam int CTRL_IE  = 3;
  localparam int CTRL_LD  = 4;

  localparam int ST_FLAG = 0;
  localparam int ST_DIR  = 1;

  localparam logic [31:0] CYCLE_RST = 32'hFFFF_FFFF;

  function automatic logic [15:0] merge16(
    input logic [15:0] old,
    input logic [15:0] d,
    input logic [1:0]  be
  );
    merge16 = old;
    if (be[1]) merge16[15:8] = d[15:8];
    if (be[0]) merge16[7:0]  = d[7:0];
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one channel with shadowed threshold/cycle, edge or
// centre counter, sticky period flag and registered output.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [1:0]  w,
  input  reg_e        idx,
  input  logic [15:0] dwrite,
  output logic [15:0] rdata,
  output logic        pwm,
  output logic        irq
);

  logic [CW-1:0] tmr, tmr_nx;
  logic [CW-1:0] sh_thres, sh_cycle;
  logic [CW-1:0] act_thres, act_cycle;
  logic [31:0]   thres_nx, cycle_nx;
  logic [31:0]   t32, h32, c32;
  logic [3:0]    ctrl;
  dir_e          dir, dir_nx;
  logic          flag, pend;
  logic          ctrl_we, ld, clr;
  logic          en, pol, ctr, ie;

  assign en  = ctrl[CTRL_EN];
  assign pol = ctrl[CTRL_POL];
  assign ctr = ctrl[CTRL_CTR];
  assign ie  = ctrl[CTRL_IE];

  assign ctrl_we = wr && w[0] && (idx == REG_CTRL);
  assign ld      = ctrl_we && dwrite[CTRL_LD];
  assign clr     = wr && w[0] && (idx == REG_STATUS)
                   && dwrite[ST_FLAG];
  assign irq     = flag && ie;

  always_comb begin
    thres_nx = 32'(sh_thres);
    cycle_nx = 32'(sh_cycle);
    if (wr) begin
      unique case (idx)
        REG_THRES_H:
          thres_nx[31:16] = merge16(thres_nx[31:16], dwrite, w);
        REG_THRES_L:
          thres_nx[15:0] = merge16(thres_nx[15:0], dwrite, w);
        REG_CYCLE_H:
          cycle_nx[31:16] = merge16(cycle_nx[31:16], dwrite, w);
        REG_CYCLE_L:
          cycle_nx[15:0] = merge16(cycle_nx[15:0], dwrite, w);
        default: ;
      endcase
    end
  end

  // Centre mode restarts at 1 after its period end, unless the
  // cycle about to be loaded is zero.
  always_comb begin
    tmr_nx = tmr;
    dir_nx = dir;
    pend   = 1'b0;
    if (!en) begin
      tmr_nx = '0;
      dir_nx = DIR_UP;
    end else if (act_cycle == '0) begin
      tmr_nx = '0;
      dir_nx = DIR_UP;
      pend   = 1'b1;
    end else if (!ctr) begin
      dir_nx = DIR_UP;
      pend   = (tmr == act_cycle);
      tmr_nx = pend ? '0 : tmr + CW'(1);
    end else if (dir == DIR_UP) begin
      if (tmr == act_cycle) begin
        dir_nx = DIR_DOWN;
        tmr_nx = tmr - CW'(1);
      end else begin
        tmr_nx = tmr + CW'(1);
      end
    end else if (tmr == '0) begin
      pend   = 1'b1;
      dir_nx = DIR_UP;
      tmr_nx = (sh_cycle == '0) ? '0 : CW'(1);
    end else begin
      tmr_nx = tmr - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr       <= '0;
      dir       <= DIR_UP;
      sh_thres  <= '0;
      act_thres <= '0;
      sh_cycle  <= CYCLE_RST[CW-1:0];
      act_cycle <= CYCLE_RST[CW-1:0];
      ctrl      <= '0;
      flag      <= 1'b0;
      pwm       <= 1'b0;
    end else begin
      sh_thres <= thres_nx[CW-1:0];
      sh_cycle <= cycle_nx[CW-1:0];
      if (ctrl_we) ctrl <= dwrite[3:0];
      pwm <= en ? ((tmr < act_thres) ^ pol) : pol;
      if (ld) begin
        tmr       <= '0;
        dir       <= DIR_UP;
        act_thres <= sh_thres;
        act_cycle <= sh_cycle;
      end else begin
        tmr <= tmr_nx;
        dir <= dir_nx;
        if (!en || pend) begin
          act_thres <= sh_thres;
          act_cycle <= sh_cycle;
        end
      end
      if (pend && !ld) flag <= 1'b1;
      else if (clr)    flag <= 1'b0;
    end
  end

  always_comb begin
    t32   = 32'(tmr);
    h32   = 32'(sh_thres);
    c32   = 32'(sh_cycle);
    rdata = '0;
    unique case (idx)
      REG_TMR_H:   rdata = t32[31:16];
      REG_TMR_L:   rdata = t32[15:0];
      REG_THRES_H: rdata = h32[31:16];
      REG_THRES_L: rdata = h32[15:0];
      REG_CYCLE_H: rdata = c32[31:16];
      REG_CYCLE_L: rdata = c32[15:0];
      REG_CTRL:    rdata[3:0] = ctrl;
      REG_STATUS: begin
        rdata[ST_FLAG] = flag;
        rdata[ST_DIR]  = (dir == DIR_DOWN);
      end
    endcase
  end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: b16 bus front end for CH PWM channels; address
// decode, read mux and interrupt OR.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CH = 4,
  parameter int CW = 32,
  parameter int AW = 4 + $clog2(CH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sel,
  input  logic          r,
  input  logic [1:0]    w,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   dwrite,
  output logic [15:0]   pwm_data,
  output logic [CH-1:0] pwm,
  output logic          irq
);

  logic [AW-1:0] chan;
  reg_e          idx;
  logic [15:0]   rd [CH];
  logic [CH-1:0] ch_irq;
  logic          unused_addr0;

  assign chan         = addr >> 4;
  assign idx          = reg_e'(addr[3:1]);
  assign unused_addr0 = addr[0];

  for (genvar i = 0; i < CH; i++) begin : g_chan
    pwm_chan #(
      .CW(CW)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .wr     (sel && (chan == AW'(i))),
      .w      (w),
      .idx    (idx),
      .dwrite (dwrite),
      .rdata  (rd[i]),
      .pwm    (pwm[i]),
      .irq    (ch_irq[i])
    );
  end

  // Channel numbers beyond CH match nothing and read as zero.
  always_comb begin
    pwm_data = '0;
    if (r && sel) begin
      for (int i = 0; i < CH; i++) begin
        if (chan == AW'(i)) pwm_data = rd[i];
      end
    end
  end

  assign irq = |ch_irq;

endmodule
